// File: rtl/rv_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : rv_mem_responder
// Purpose  : Memory model for one core memory channel. It has valid/ready
//            request and response channels, a configurable access latency,
//            byte-enable stores, credit-bounded outstanding requests and a
//            host load/inspect port that takes priority over the core side.
// Options  : RV_MEM_ALIGN_CHECK_EN - flags misaligned or out-of-range core
//            accesses on o_err, suppresses their stores and returns
//            0xDEADBEEF as read data.
// Revision : 1.0 - initial release
// ============================================================================
module rv_mem_responder #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 1,
  parameter int RESP_DEPTH = 2
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst,
  input  logic                                    i_req_valid,
  output logic                                    o_req_ready,
  input  logic [DATA_W/8+ADDR_W+DATA_W-1:0]       i_req_data,
  output logic                                    o_resp_valid,
  input  logic                                    i_resp_ready,
  output logic [DATA_W/8+ADDR_W+DATA_W-1:0]       o_resp_data,
  input  logic                                    i_host_en,
  input  logic                                    i_host_we,
  input  logic [DEPTH_LOG2-1:0]                   i_host_addr,
  input  logic [DATA_W-1:0]                       i_host_wdata,
  output logic [DATA_W-1:0]                       o_host_rdata,
  output logic                                    o_err
);

  localparam int c_BE     = DATA_W / 8;
  localparam int c_RESP_W = c_BE + ADDR_W + DATA_W;
  localparam int c_PTR_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int c_CNT_W  = $clog2(RESP_DEPTH + 1);
  localparam int c_WORDS  = 1 << DEPTH_LOG2;

  localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(RESP_DEPTH - 1);
  localparam logic [c_CNT_W-1:0] c_CREDITS  = c_CNT_W'(RESP_DEPTH);

  // Storage; contents survive reset on purpose so a program image stays put.
  logic [DATA_W-1:0] r_mem [0:c_WORDS-1];

  // Request fields
  logic [c_BE-1:0]       w_req_be;
  logic [ADDR_W-1:0]     w_req_addr;
  logic [DATA_W-1:0]     w_req_wdata;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_fire;
  logic                  w_is_store;
  logic                  w_bad;
  logic [DATA_W-1:0]     w_rdata;
  logic [c_RESP_W-1:0]   w_stage0;

  // Pipeline output feeding the response FIFO
  logic                  w_push;
  logic [c_RESP_W-1:0]   w_push_data;
  logic                  w_pop;

  // Response FIFO and credit state
  logic [c_RESP_W-1:0]   r_fifo [0:RESP_DEPTH-1];
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_CNT_W-1:0]    r_count;
  logic [c_CNT_W-1:0]    r_outst;
  logic [DATA_W-1:0]     r_host_rdata;

  // Low address bits and the bits above the word index are don't-care unless
  // the alignment check is compiled in.
  logic w_unused_addr;
  assign w_unused_addr = ^w_req_addr;

  assign {w_req_be, w_req_addr, w_req_wdata} = i_req_data;
  assign w_idx      = w_req_addr[DEPTH_LOG2+1:2];
  assign w_is_store = |w_req_be;

  // Outstanding = in pipeline + in FIFO, so a push can never find the FIFO full.
  assign o_req_ready = !i_rst && !i_host_en && (r_outst < c_CREDITS);
  assign w_fire      = i_req_valid && o_req_ready;

`ifdef RV_MEM_ALIGN_CHECK_EN
  localparam logic [DATA_W-1:0] c_BAD_WORD = DATA_W'(32'hDEADBEEF);
  logic w_hi_bad;
  logic r_err;

  if (ADDR_W > DEPTH_LOG2 + 2) begin : g_hi_chk
    assign w_hi_bad = |w_req_addr[ADDR_W-1:DEPTH_LOG2+2];
  end else begin : g_no_hi_chk
    assign w_hi_bad = 1'b0;
  end

  assign w_bad   = (w_req_addr[1:0] != 2'b00) || w_hi_bad;
  assign w_rdata = w_bad ? c_BAD_WORD : r_mem[w_idx];

  // Sticky error: set by any accepted bad access, cleared only by reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else if (w_fire && w_bad) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  assign w_bad   = 1'b0;
  assign w_rdata = r_mem[w_idx];
  assign o_err   = 1'b0;
`endif

  // Read data is the pre-write word, sampled in the accept cycle.
  assign w_stage0 = {w_req_be, w_req_addr, w_rdata};

  // The accept cycle itself counts as the first latency stage, so only
  // LATENCY-1 register stages sit between accept and the FIFO push.
  if (LATENCY == 1) begin : g_lat_direct
    assign w_push      = w_fire;
    assign w_push_data = w_stage0;
  end else begin : g_lat_pipe
    logic [LATENCY-2:0]  r_vld;
    logic [c_RESP_W-1:0] r_dat [0:LATENCY-2];

    // Shift {valid, response} one stage per cycle; reset drops in-flight work
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_vld <= '0;
      end else begin
        r_vld[0] <= w_fire;
        r_dat[0] <= w_stage0;
        for (int s = 1; s < LATENCY - 1; s++) begin
          r_vld[s] <= r_vld[s-1];
          r_dat[s] <= r_dat[s-1];
        end
      end
    end

    assign w_push      = r_vld[LATENCY-2];
    assign w_push_data = r_dat[LATENCY-2];
  end

  function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // FIFO head drives the response channel directly, so it holds while stalled.
  assign o_resp_valid = (r_count != '0);
  assign o_resp_data  = r_fifo[r_rd_ptr];
  assign w_pop        = o_resp_valid && i_resp_ready;

  // Response FIFO pointers and occupancy
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_push_data;
        r_wr_ptr         <= f_next(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= f_next(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Credit counter: taken on accept, returned when the core consumes a response
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_outst <= '0;
    end else begin
      case ({w_fire, w_pop})
        2'b10:   r_outst <= r_outst + 1'b1;
        2'b01:   r_outst <= r_outst - 1'b1;
        default: r_outst <= r_outst;
      endcase
    end
  end

  // Memory writes: host full-word writes win; core stores write enabled lanes
  always_ff @(posedge i_clk) begin
    if (i_host_en && i_host_we) begin
      r_mem[i_host_addr] <= i_host_wdata;
    end else if (w_fire && w_is_store && !w_bad) begin
      for (int b = 0; b < c_BE; b++) begin
        if (w_req_be[b]) begin
          r_mem[w_idx][b*8 +: 8] <= w_req_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Host read returns the pre-edge word next cycle and holds otherwise
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_host_rdata <= '0;
    end else if (i_host_en && !i_host_we) begin
      r_host_rdata <= r_mem[i_host_addr];
    end
  end

  assign o_host_rdata = r_host_rdata;

endmodule
`default_nettype wire

// File: tb/tb_rv_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_mem_responder
// Purpose  : Self-checking bench for rv_mem_responder. One instance runs with
//            LATENCY=1 (table-driven load/store vectors), one with LATENCY=3
//            and RESP_DEPTH=2 (backpressure, host priority, mid-flight reset).
//            Define RV_MEM_ALIGN_CHECK_EN to exercise the error path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance 1: LATENCY=1
  logic        rst1, req_valid1, req_ready1, resp_valid1, resp_ready1;
  logic [67:0] req_data1, resp_data1;
  logic        host_en1, host_we1, err1;
  logic [5:0]  host_addr1;
  logic [31:0] host_wdata1, host_rdata1;

  // Instance 3: LATENCY=3, RESP_DEPTH=2
  logic        rst3, req_valid3, req_ready3, resp_valid3, resp_ready3;
  logic [67:0] req_data3, resp_data3;
  logic        host_en3, host_we3, err3;
  logic [5:0]  host_addr3;
  logic [31:0] host_wdata3, host_rdata3;

  rv_mem_responder #(
    .ADDR_W(32), .DATA_W(32), .DEPTH_LOG2(6), .LATENCY(1), .RESP_DEPTH(2)
  ) u_dut1 (
    .i_clk(clk), .i_rst(rst1),
    .i_req_valid(req_valid1), .o_req_ready(req_ready1), .i_req_data(req_data1),
    .o_resp_valid(resp_valid1), .i_resp_ready(resp_ready1), .o_resp_data(resp_data1),
    .i_host_en(host_en1), .i_host_we(host_we1), .i_host_addr(host_addr1),
    .i_host_wdata(host_wdata1), .o_host_rdata(host_rdata1), .o_err(err1)
  );

  rv_mem_responder #(
    .ADDR_W(32), .DATA_W(32), .DEPTH_LOG2(6), .LATENCY(3), .RESP_DEPTH(2)
  ) u_dut3 (
    .i_clk(clk), .i_rst(rst3),
    .i_req_valid(req_valid3), .o_req_ready(req_ready3), .i_req_data(req_data3),
    .o_resp_valid(resp_valid3), .i_resp_ready(resp_ready3), .o_resp_data(resp_data3),
    .i_host_en(host_en3), .i_host_we(host_we3), .i_host_addr(host_addr3),
    .i_host_wdata(host_wdata3), .o_host_rdata(host_rdata3), .o_err(err3)
  );

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic host_wr1(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    host_en1 = 1'b1; host_we1 = 1'b1; host_addr1 = a; host_wdata1 = d;
    @(negedge clk);
    host_en1 = 1'b0; host_we1 = 1'b0;
  endtask

  task automatic host_wr3(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    host_en3 = 1'b1; host_we3 = 1'b1; host_addr3 = a; host_wdata3 = d;
    @(negedge clk);
    host_en3 = 1'b0; host_we3 = 1'b0;
  endtask

  // One request on the LATENCY=1 instance; response must appear the next cycle
  task automatic txn1(input string nm, input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] exp_rd);
    @(negedge clk);
    check({nm, " idle"}, resp_valid1, 1'b0);
    req_valid1 = 1'b1; req_data1 = {be, addr, wd};
    #1;
    check({nm, " ready"}, req_ready1, 1'b1);
    @(negedge clk);
    req_valid1 = 1'b0;
    check({nm, " rvalid"}, resp_valid1, 1'b1);
    check({nm, " rdata"}, resp_data1[31:0], exp_rd);
    check({nm, " rbe"}, resp_data1[67:64], be);
    check({nm, " raddr"}, resp_data1[63:32], addr);
  endtask

  // Load on the LATENCY=3 instance with bounded waits (resp_ready3 must be 1)
  task automatic load3(input string nm, input logic [31:0] addr, input logic [31:0] exp_rd);
    bit got;
    got = 1'b0;
    @(negedge clk);
    req_valid3 = 1'b1; req_data3 = {4'b0, addr, 32'h0};
    #1;
    check({nm, " ready"}, req_ready3, 1'b1);
    for (int c = 0; c < 12 && !got; c++) begin
      @(negedge clk);
      req_valid3 = 1'b0;
      if (resp_valid3) begin
        got = 1'b1;
        check({nm, " rdata"}, resp_data3[31:0], exp_rd);
        check({nm, " raddr"}, resp_data3[63:32], addr);
        check({nm, " latency"}, 128'(c), 128'd2);
      end
    end
    check({nm, " response seen"}, got, 1'b1);
  endtask

  typedef struct {
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [10];

  logic [67:0] snap;
  logic        last_rdy;
  int          k, nresp, stale;
  bit          got4;

  initial begin
    rst1 = 1'b1; req_valid1 = 1'b0; req_data1 = '0; resp_ready1 = 1'b1;
    host_en1 = 1'b0; host_we1 = 1'b0; host_addr1 = '0; host_wdata1 = '0;
    rst3 = 1'b1; req_valid3 = 1'b0; req_data3 = '0; resp_ready3 = 1'b0;
    host_en3 = 1'b0; host_we3 = 1'b0; host_addr3 = '0; host_wdata3 = '0;

    // Memory evolves across the table: idx4 starts 0x12345678, idx5 0x11111111,
    // idx6 0, idx63 0xFEDCBA98 (loaded through the host port below).
    vecs[0] = '{4'b0000, 32'h10, 32'h0,         32'h1234_5678};
    vecs[1] = '{4'b0101, 32'h10, 32'hAABB_CCDD, 32'h1234_5678};
    vecs[2] = '{4'b0000, 32'h10, 32'h0,         32'h12BB_56DD};
    vecs[3] = '{4'b1111, 32'h14, 32'hCAFE_F00D, 32'h1111_1111};
    vecs[4] = '{4'b0000, 32'h14, 32'h0,         32'hCAFE_F00D};
    vecs[5] = '{4'b0010, 32'h18, 32'h0000_AB00, 32'h0000_0000};
    vecs[6] = '{4'b0000, 32'h18, 32'h0,         32'h0000_AB00};
    vecs[7] = '{4'b1000, 32'h10, 32'h7700_0000, 32'h12BB_56DD};
    vecs[8] = '{4'b0000, 32'h10, 32'h0,         32'h77BB_56DD};
    vecs[9] = '{4'b0000, 32'hFC, 32'h0,         32'hFEDC_BA98};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst ready1", req_ready1, 1'b0);
    check("rst rvalid1", resp_valid1, 1'b0);
    check("rst hrdata1", host_rdata1, 32'h0);
    check("rst err1", err1, 1'b0);
    check("rst ready3", req_ready3, 1'b0);
    check("rst rvalid3", resp_valid3, 1'b0);
    @(negedge clk);
    rst1 = 1'b0; rst3 = 1'b0;

    host_wr1(6'd4, 32'h1234_5678);
    host_wr1(6'd5, 32'h1111_1111);
    host_wr1(6'd6, 32'h0000_0000);
    host_wr1(6'd63, 32'hFEDC_BA98);

    // Host read: value next cycle, then held
    @(negedge clk);
    host_en1 = 1'b1; host_we1 = 1'b0; host_addr1 = 6'd63;
    @(negedge clk);
    host_en1 = 1'b0;
    check("host read", host_rdata1, 32'hFEDC_BA98);
    @(negedge clk);
    check("host read hold", host_rdata1, 32'hFEDC_BA98);

    for (int i = 0; i < 10; i++) begin
      txn1($sformatf("vec%0d", i), vecs[i].be, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd);
    end

`ifdef RV_MEM_ALIGN_CHECK_EN
    txn1("bad store", 4'b1111, 32'h11, 32'h0, 32'hDEAD_BEEF);
    check("err set", err1, 1'b1);
    txn1("bad range", 4'b0000, 32'h110, 32'h0, 32'hDEAD_BEEF);
    txn1("no store", 4'b0000, 32'h10, 32'h0, 32'h77BB_56DD);
    check("err sticky", err1, 1'b1);
`else
    // Upper address bits wrap, low two bits are ignored
    txn1("wrap store", 4'b1000, 32'h110, 32'h9900_0000, 32'h77BB_56DD);
    txn1("offset load", 4'b0000, 32'h13, 32'h0, 32'h99BB_56DD);
    check("err tied", err1, 1'b0);
`endif

    // Backpressure with LATENCY=3, RESP_DEPTH=2
    for (int i = 0; i < 4; i++) host_wr3(6'(i), 32'hA0A0_0000 | 32'(i));
    k = 0; nresp = 0; last_rdy = 1'b1; snap = '0;
    for (int cyc = 0; cyc < 40 && nresp < 4; cyc++) begin
      @(negedge clk);
      if (cyc == 8) begin
        check("t3 accepted", 128'(k), 128'd2);
        check("t3 ready low", last_rdy, 1'b0);
        check("t3 held valid", resp_valid3, 1'b1);
      end
      if (cyc == 5) snap = resp_data3;
      if (cyc == 7) check("t3 stable", resp_data3, snap);
      resp_ready3 = (cyc >= 8);
      if (k < 4) begin
        req_valid3 = 1'b1; req_data3 = {4'b0, 32'(k * 4), 32'h0};
      end else begin
        req_valid3 = 1'b0;
      end
      #1;
      last_rdy = req_ready3;
      if (req_valid3 && last_rdy) k++;
      if (resp_valid3 && resp_ready3) begin
        check($sformatf("t3 rdata%0d", nresp), resp_data3[31:0], 32'hA0A0_0000 | 32'(nresp));
        check($sformatf("t3 raddr%0d", nresp), resp_data3[63:32], 32'(nresp * 4));
        nresp++;
      end
    end
    req_valid3 = 1'b0;
    check("t3 all accepted", 128'(k), 128'd4);
    check("t3 all responses", 128'(nresp), 128'd4);
    repeat (2) @(negedge clk);

    // Host access mid-stream
    @(negedge clk);
    req_valid3 = 1'b1; req_data3 = {4'b0, 32'h4, 32'h0};
    #1;
    check("t4 ready", req_ready3, 1'b1);
    @(negedge clk);
    req_data3 = {4'b0, 32'h8, 32'h0};
    host_en3 = 1'b1; host_we3 = 1'b0; host_addr3 = 6'd2;
    #1;
    check("t4 host blocks", req_ready3, 1'b0);
    @(negedge clk);
    host_addr3 = 6'd3;
    check("t4 host rd", host_rdata3, 32'hA0A0_0002);
    check("t4 still blocked", req_ready3, 1'b0);
    @(negedge clk);
    check("t4 inflight valid", resp_valid3, 1'b1);
    check("t4 inflight rdata", resp_data3[31:0], 32'hA0A0_0001);
    check("t4 host rd2", host_rdata3, 32'hA0A0_0003);
    @(negedge clk);
    host_en3 = 1'b0;
    #1;
    check("t4 ready again", req_ready3, 1'b1);
    check("t4 host hold", host_rdata3, 32'hA0A0_0003);
    got4 = 1'b0;
    for (int c = 0; c < 10 && !got4; c++) begin
      @(negedge clk);
      req_valid3 = 1'b0;
      if (resp_valid3) begin
        got4 = 1'b1;
        check("t4 second rdata", resp_data3[31:0], 32'hA0A0_0002);
      end
    end
    check("t4 second seen", got4, 1'b1);
    repeat (2) @(negedge clk);

    // Reset with two requests in flight
    @(negedge clk);
    req_valid3 = 1'b1; req_data3 = {4'b0, 32'h0, 32'h0};
    #1;
    check("t5 ready a", req_ready3, 1'b1);
    @(negedge clk);
    req_data3 = {4'b0, 32'h4, 32'h0};
    #1;
    check("t5 ready b", req_ready3, 1'b1);
    @(negedge clk);
    req_valid3 = 1'b0; rst3 = 1'b1;
    #1;
    check("t5 ready in rst", req_ready3, 1'b0);
    @(negedge clk);
    rst3 = 1'b0;
    check("t5 rvalid cleared", resp_valid3, 1'b0);
    check("t5 hrdata cleared", host_rdata3, 32'h0);
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (resp_valid3) stale++;
    end
    check("t5 no stale", 128'(stale), 128'd0);
    load3("t5 retained", 32'h0, 32'hA0A0_0000);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
